// File: rtl/layer27_argmax_target_pkg.sv
// Shared definitions for the layer-27 scoring stage: the layer output type and its extreme values.
package layer27_argmax_target_pkg;

    typedef logic [7:0] zero2one_t;

    localparam zero2one_t ZERO2ONE_MAX = 8'hFF;
    localparam zero2one_t ZERO2ONE_MIN = 8'h00;

endpackage

// File: rtl/layer27_argmax_target_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            value <= '0;
        end else if (inc && (value != {WIDTH{1'b1}})) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/layer27_argmax_target.sv
// Serial argmax over a snapshot of the layer outputs, producing the one-hot learn target and accuracy stats.
//
// state    | meaning
// S_IDLE   | waiting for start; snapshot taken on start
// S_SCAN   | compare one snapshot element per cycle, indices 1..N-1
// S_DECIDE | results registered on the edge leaving this state
module layer27_argmax_target
    import layer27_argmax_target_pkg::*;
#(
    parameter int N            = 27,
    parameter int IDX_W        = $clog2(N),
    parameter int CNT_W        = 16,
    parameter bit ALWAYS_LEARN = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] label,
    input  zero2one_t        in [N],
    input  logic             clear_stats,
    output logic             busy,
    output logic             done,
    output logic             learn,
    output logic [IDX_W-1:0] predicted,
    output logic             correct,
    output logic             label_err,
    output zero2one_t        expected_out [N],
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

    state_t           state, state_nxt;
    zero2one_t        snap [N];
    logic [IDX_W-1:0] lbl;
    zero2one_t        best_val;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             decide_c;
    logic             lbl_err_c;
    logic             correct_c;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SCAN;
            S_SCAN:   if (scan_idx == LAST_IDX) state_nxt = S_DECIDE;
            S_DECIDE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        decide_c  = (state == S_DECIDE);
        lbl_err_c = ({1'b0, lbl} >= N_EXT);
        correct_c = !lbl_err_c && (best_idx == lbl);
    end

    assign busy = (state != S_IDLE);

    // Scan datapath needs no reset: it is always reloaded from the snapshot on start.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start) begin
            snap     <= in;
            lbl      <= label;
            best_val <= in[0];
            best_idx <= '0;
            scan_idx <= IDX_W'(1);
        end else if (state == S_SCAN) begin
            if (snap[scan_idx] > best_val) begin
                best_val <= snap[scan_idx];
                best_idx <= scan_idx;
            end
            scan_idx <= scan_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done      <= 1'b0;
            learn     <= 1'b0;
            predicted <= '0;
            correct   <= 1'b0;
            label_err <= 1'b0;
            for (int i = 0; i < N; i++) expected_out[i] <= ZERO2ONE_MIN;
        end else begin
            done  <= 1'b0;
            learn <= 1'b0;
            if (decide_c) begin
                done      <= 1'b1;
                learn     <= !lbl_err_c && (ALWAYS_LEARN || !correct_c);
                predicted <= best_idx;
                correct   <= correct_c;
                label_err <= lbl_err_c;
                for (int i = 0; i < N; i++)
                    expected_out[i] <= (!lbl_err_c && IDX_W'(i) == lbl) ? ZERO2ONE_MAX : ZERO2ONE_MIN;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_stats),
        .inc   (decide_c),
        .value (sample_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_stats),
        .inc   (decide_c && correct_c),
        .value (hit_count)
    );

endmodule
